// File: rtl/cpu_step_ctrl.sv
// Run/step scheduler: turns run mode, debounced single-step presses and PC
// breakpoints into a one-cycle processor clock enable plus display snapshots.
module cpu_step_ctrl #(
    parameter int PC_W    = 8,
    parameter int RATE_W  = 24,
    parameter int DEB_CNT = 250000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_step,
    input  logic              sw_run,
    input  logic              sw_bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [RATE_W-1:0] rate,
    input  logic [PC_W-1:0]   pc,
    input  logic              reg_write_w,
    input  logic [15:0]       result_w,
    output logic              cpu_en,
    output logic              halted,
    output logic              bp_hit,
    output logic [PC_W-1:0]   snap_pc,
    output logic [15:0]       snap_result,
    output logic [15:0]       step_count
);
    localparam int DEB_W = $clog2(DEB_CNT);

    typedef enum logic [1:0] {IDLE, RUN, BP_HALT} state_t;

    logic [1:0]        sync_reg;
    logic [DEB_W-1:0]  deb_cnt_reg;
    logic              deb_level_reg;
    logic              deb_level_d_reg;
    logic              step_req;

    state_t            state_reg, state_next;
    logic [RATE_W-1:0] rate_cnt_reg, rate_cnt_next;
    logic              cpu_en_reg, cpu_en_next;
    logic              halted_reg, halted_next;
    logic              bp_hit_reg, bp_hit_next;
    logic [PC_W-1:0]   snap_pc_reg;
    logic [15:0]       snap_result_reg;
    logic [15:0]       step_count_reg;
    logic              rate_hit;
    logic              bp_match;

    // Level only flips after DEB_CNT consecutive cycles of disagreement.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg        <= '0;
            deb_cnt_reg     <= '0;
            deb_level_reg   <= 1'b0;
            deb_level_d_reg <= 1'b0;
        end else begin
            sync_reg        <= {sync_reg[0], btn_step};
            deb_level_d_reg <= deb_level_reg;
            if (sync_reg[1] == deb_level_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_W'(DEB_CNT - 1)) begin
                deb_level_reg <= ~deb_level_reg;
                deb_cnt_reg   <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
        end
    end

    assign step_req = deb_level_reg & ~deb_level_d_reg;
    assign rate_hit = (rate_cnt_reg == rate);
    assign bp_match = sw_bp_en && (pc == bp_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            rate_cnt_reg <= '0;
            cpu_en_reg   <= 1'b0;
            halted_reg   <= 1'b1;
            bp_hit_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rate_cnt_reg <= rate_cnt_next;
            cpu_en_reg   <= cpu_en_next;
            halted_reg   <= halted_next;
            bp_hit_reg   <= bp_hit_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rate_cnt_next = rate_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (sw_run) begin
                    state_next    = RUN;
                    rate_cnt_next = '0;
                end
            end
            RUN: begin
                if (!sw_run) begin
                    state_next = IDLE;
                end else if (rate_hit) begin
                    rate_cnt_next = '0;
                    if (bp_match) state_next = BP_HALT;
                end else begin
                    rate_cnt_next = rate_cnt_reg + RATE_W'(1);
                end
            end
            BP_HALT: begin
                if (step_req) begin
                    state_next    = sw_run ? RUN : IDLE;
                    rate_cnt_next = '0;
                end else if (!sw_run) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so they line up with it.
    always_comb begin
        cpu_en_next = 1'b0;
        case (state_reg)
            IDLE:    cpu_en_next = !sw_run && step_req;
            RUN:     cpu_en_next = sw_run && rate_hit && !bp_match;
            BP_HALT: cpu_en_next = step_req;
            default: cpu_en_next = 1'b0;
        endcase
        halted_next = (state_next != RUN);
        bp_hit_next = (state_next == BP_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_pc_reg     <= '0;
            snap_result_reg <= '0;
            step_count_reg  <= '0;
        end else if (cpu_en_next) begin
            snap_pc_reg    <= pc;
            step_count_reg <= step_count_reg + 16'd1;
            if (reg_write_w) snap_result_reg <= result_w;
        end
    end

    assign cpu_en      = cpu_en_reg;
    assign halted      = halted_reg;
    assign bp_hit      = bp_hit_reg;
    assign snap_pc     = snap_pc_reg;
    assign snap_result = snap_result_reg;
    assign step_count  = step_count_reg;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed and randomized checks of cpu_step_ctrl against a timing model
// derived from the run period, debounce latency and breakpoint rules.
module tb_cpu_step_ctrl;
    localparam int PC_W   = 8;
    localparam int RATE_W = 6;
    localparam int DEB    = 4;
    localparam int WRAP   = 2 ** RATE_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              btn_step;
    logic              sw_run;
    logic              sw_bp_en;
    logic [PC_W-1:0]   bp_addr;
    logic [RATE_W-1:0] rate;
    logic [PC_W-1:0]   pc;
    logic              reg_write_w;
    logic [15:0]       result_w;
    logic              cpu_en;
    logic              halted;
    logic              bp_hit;
    logic [PC_W-1:0]   snap_pc;
    logic [15:0]       snap_result;
    logic [15:0]       step_count;

    int errors = 0;
    int checks = 0;

    logic [15:0]     exp_count;
    logic [PC_W-1:0] exp_spc;
    logic [15:0]     exp_sres;

    cpu_step_ctrl #(.PC_W(PC_W), .RATE_W(RATE_W), .DEB_CNT(DEB)) dut (
        .clk(clk), .rst(rst), .btn_step(btn_step), .sw_run(sw_run),
        .sw_bp_en(sw_bp_en), .bp_addr(bp_addr), .rate(rate), .pc(pc),
        .reg_write_w(reg_write_w), .result_w(result_w), .cpu_en(cpu_en),
        .halted(halted), .bp_hit(bp_hit), .snap_pc(snap_pc),
        .snap_result(snap_result), .step_count(step_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic jitter();
        pc          = PC_W'($urandom);
        result_w    = 16'($urandom);
        reg_write_w = 1'($urandom);
    endtask

    // One clock: update the scoreboard with what this edge should do, then compare.
    task automatic tick(input bit exp_en);
        logic [PC_W-1:0] pc_s;
        logic [15:0]     res_s;
        logic            rw_s;
        logic            rst_s;
        pc_s  = pc;
        res_s = result_w;
        rw_s  = reg_write_w;
        rst_s = rst;
        @(posedge clk);
        #1;
        if (rst_s) begin
            exp_count = '0;
            exp_spc   = '0;
            exp_sres  = '0;
        end else if (exp_en) begin
            exp_count = exp_count + 16'd1;
            exp_spc   = pc_s;
            if (rw_s) exp_sres = res_s;
        end
        check("cpu_en", 32'(cpu_en), 32'(exp_en && !rst_s));
        check("step_count", 32'(step_count), 32'(exp_count));
        check("snap_pc", 32'(snap_pc), 32'(exp_spc));
        check("snap_result", 32'(snap_result), 32'(exp_sres));
    endtask

    initial begin
        int holds [7];
        int rr;
        int len;
        int first;

        rst = 1'b1; btn_step = 1'b0; sw_run = 1'b0; sw_bp_en = 1'b0;
        bp_addr = '0; rate = '0; pc = '0; reg_write_w = 1'b0; result_w = '0;
        exp_count = '0; exp_spc = '0; exp_sres = '0;

        tick(1'b0);
        check("reset_halted", 32'(halted), 32'd1);
        check("reset_bp_hit", 32'(bp_hit), 32'd0);
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            jitter();
            tick(1'b0);
        end
        check("idle_halted", 32'(halted), 32'd1);

        // Button presses: a pulse only when held for at least DEB cycles.
        holds[0] = 10; holds[1] = 3; holds[2] = DEB; holds[3] = DEB - 1;
        for (int p = 4; p < 7; p++) holds[p] = $urandom_range(1, 2 * DEB);
        for (int p = 0; p < 7; p++) begin
            for (int j = 0; j < holds[p] + 2 * DEB + 6; j++) begin
                btn_step = (j < holds[p]);
                jitter();
                if (p == 0) begin
                    reg_write_w = 1'b1;
                    result_w    = 16'hBEEF;
                end else if (p == 2) begin
                    reg_write_w = 1'b0;
                end
                tick(holds[p] >= DEB && j == DEB + 2);
            end
            $display("press hold=%0d step_count=%0d snap_pc=%0h", holds[p], step_count, snap_pc);
            if (p == 2) check("snap_result_hold", 32'(snap_result), 32'h0000BEEF);
        end

        // Run at rate 3 with a button press that must be dropped; stop on a due edge.
        rate = 6'd3;
        for (int j = 0; j <= 40; j++) begin
            sw_run   = (j < 40);
            btn_step = (j < 10);
            jitter();
            tick(j > 0 && j < 40 && j % 4 == 0);
            if (j == 20) check("run_halted", 32'(halted), 32'd0);
        end
        check("stop_halted", 32'(halted), 32'd1);
        $display("run rate=3 step_count=%0d", step_count);
        for (int j = 0; j < 10; j++) begin
            jitter();
            tick(1'b0);
        end

        // Random rates, including rate 0 (enable every cycle).
        for (int r = 0; r < 5; r++) begin
            rate = (r == 0) ? 6'd0 : 6'($urandom_range(0, 7));
            rr   = int'(rate);
            len  = $urandom_range(15, 40);
            for (int j = 0; j <= len; j++) begin
                sw_run = (j < len);
                jitter();
                tick(j > 0 && j < len && (j % (rr + 1)) == 0);
            end
            $display("run rate=%0d len=%0d step_count=%0d", rr, len, step_count);
            for (int j = 0; j < 3; j++) tick(1'b0);
        end

        // Step request and run switch arriving on the same edge in IDLE: run wins.
        rate = 6'd2;
        for (int j = 0; j <= 24; j++) begin
            btn_step = (j < 8);
            sw_run   = (j >= DEB + 2 && j < 24);
            jitter();
            tick(j > DEB + 2 && j < 24 && ((j - (DEB + 2)) % 3) == 0);
        end
        $display("step+run collision step_count=%0d", step_count);
        for (int j = 0; j < 12; j++) tick(1'b0);

        // Rate lowered below the running count: must wrap before matching.
        rate   = 6'd10;
        first  = WRAP + 3;
        for (int j = 0; j <= 80; j++) begin
            if (j == 6) rate = 6'd2;
            sw_run = (j < 80);
            jitter();
            tick(j >= first && j < 80 && ((j - first) % 3) == 0);
        end
        $display("rate change step_count=%0d", step_count);
        tick(1'b0);

        // Breakpoint at 0x10 with PC advancing by 4 on each enable.
        sw_bp_en = 1'b1; bp_addr = 8'h10; rate = 6'd1; pc = 8'h08; sw_run = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick(j == 2 || j == 4);
            if (j == 2 || j == 4) pc = pc + 8'd4;
        end
        check("bp_hit", 32'(bp_hit), 32'd1);
        check("bp_halted", 32'(halted), 32'd1);
        check("bp_pc", 32'(pc), 32'h10);
        for (int k = 0; k <= 20; k++) begin
            btn_step = (k < 8);
            sw_run   = (k < 20);
            tick(k == DEB + 2 || (k > DEB + 2 && k < 20 && ((k - (DEB + 2)) % 2) == 0));
            if (k == DEB + 2 || (k > DEB + 2 && k < 20 && ((k - (DEB + 2)) % 2) == 0))
                pc = pc + 8'd4;
            if (k == DEB + 1) check("bp_hold", 32'(bp_hit), 32'd1);
            if (k == DEB + 2) begin
                check("bp_release", 32'(bp_hit), 32'd0);
                check("bp_resume", 32'(halted), 32'd0);
            end
        end
        $display("breakpoint resume step_count=%0d snap_pc=%0h", step_count, snap_pc);
        sw_bp_en = 1'b0;
        for (int j = 0; j < 12; j++) tick(1'b0);

        // Reset on the edge a pulse would be due.
        rate = 6'd2; sw_run = 1'b1;
        for (int j = 0; j < 3; j++) begin
            jitter();
            tick(1'b0);
        end
        rst = 1'b1;
        tick(1'b0);
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_bp_hit", 32'(bp_hit), 32'd0);
        rst = 1'b0; sw_run = 1'b0;
        tick(1'b0);
        tick(1'b0);
        $display("mid-run reset step_count=%0d", step_count);

        // Step count wrap using continuous enables.
        rate = 6'd0; sw_run = 1'b1;
        for (int j = 0; j <= 65536; j++) begin
            jitter();
            tick(j > 0);
            if (j == 65535) check("count_max", 32'(step_count), 32'h0000FFFF);
            if (j == 65536) check("count_wrap", 32'(step_count), 32'd0);
        end
        sw_run = 1'b0;
        tick(1'b0);
        $display("wrap step_count=%0d", step_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
